ex_mem_forward: RTL and testbench
=================================

EX_MEM_FORWARD -- requirements
Module: ex_mem_forward

Interface
REQ-001 SHALL have ports: clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have: valid_EX  in  1  EX stage holds a real instruction (0 = bubble).
REQ-004 SHALL have: RD  in  5  EX destination register.
REQ-005 SHALL have: saidaULA  in  32  EX ALU result.
REQ-006 SHALL have: dado2ALU_out  in  32  EX store data.
REQ-007 SHALL have: saidaSomador  in  32  EX branch target.
REQ-008 SHALL have: zeroEx  in  1  EX ALU zero flag.
REQ-009 SHALL have: ctrl_EX  in  5  {regWrite, memRead, memWrite, memToReg, branch}.
REQ-010 SHALL have: rs_ID, rt_ID  in  5 each  source registers of the instruction in ID.
REQ-011 SHALL have: dadoMem  in  32  data-memory read data for the MEM instruction, same cycle.
REQ-012 SHALL have: resultadoALU_MEM  out  32;  dado2_MEM  out  32;  memRead_MEM, memWrite_MEM  out  1 each.
REQ-013 SHALL have: pcSrc  out  1;  destino  out  32  registered branch target.
REQ-014 SHALL have: resultadoMux_WB  out  32;  RD_WB  out  5;  regWrite_WB  out  1.
REQ-015 SHALL have: saidaAfw, saidaBfw  out  2 each  forward selects for next EX;  stall  out  1.

Function
REQ-016 EX/MEM register SHALL capture EX inputs every edge; captured control bits SHALL be forced 0 when valid_EX=0 or pcSrc=1 (flush).
REQ-017 pcSrc SHALL equal branch_MEM AND zero_MEM, combinational from EX/MEM register.
REQ-018 MEM/WB register SHALL capture RD, regWrite, memToReg, ALU result and dadoMem from MEM every edge.
REQ-019 resultadoMux_WB SHALL be dadoMem_WB when memToReg_WB=1, else ALU result of WB.
REQ-020 Forward codes SHALL be registered: per source (rs_ID -> saidaAfw, rt_ID -> saidaBfw), next value 10 if regWrite_EX-effective, RD!=0 and RD==source; else 01 if regWrite_MEM, RD_MEM!=0 and RD_MEM==source; else 00.
REQ-021 MEM match (10) SHALL take priority over WB match (01) when both hit.
REQ-022 stall SHALL be combinational: 1 when valid_EX, memRead_EX, RD!=0 and RD equals rs_ID or rt_ID (load-use), else 0.
REQ-023 During stall the ID instruction is held upstream; this block SHALL keep recomputing codes each cycle so the dependent instruction receives 01 when it finally enters EX.
REQ-024 Register 0 SHALL never be forwarded nor cause a stall.
REQ-025 Latency: EX result visible on resultadoALU_MEM exactly 1 cycle later, on resultadoMux_WB 2 cycles later.

Reset
REQ-026 With reset_n=0 at an edge, all registered outputs and internal registers SHALL become 0 (codes 00, pcSrc 0, regWrite_WB 0); stall SHALL be forced 0 while reset_n=0.
REQ-027 Reset mid-operation SHALL discard all in-flight instructions; no write-back SHALL occur the cycle after reset release.

Configuration
REQ-028 Macro HAZARD_FORWARD_EN defined: behaviour per REQ-020..022.
REQ-029 Macro undefined: saidaAfw/saidaBfw SHALL stay 00; stall SHALL assert for any source match against valid EX (regWrite) or MEM (regWrite) destination, RD!=0.

Structure
REQ-030 Shared package SHALL hold FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, control-bit indices of ctrl_EX, and register-index width 5.
REQ-031 Comparison logic SHALL be one sub-module hazard_compare, instantiated once per source register.

Verification
REQ-032 add r3 in EX (RD=3), rs_ID=3 -> next cycle saidaAfw=10, resultadoALU_MEM=EX result.
REQ-033 r3 in MEM and in EX both writing, rt_ID=3 -> saidaBfw=10 (priority).
REQ-034 lw r5 in EX, rt_ID=5 -> stall=1 that cycle; two cycles later saidaBfw=01, resultadoMux_WB=dadoMem value 0x0000_00AA.
REQ-035 beq with zeroEx=1, saidaSomador=0x40 -> next cycle pcSrc=1, destino=0x40, following EX/MEM capture has all control 0.
REQ-036 RD=0 with regWrite, rs_ID=0 -> codes 00, stall 0.
REQ-037 reset_n=0 for one edge mid-stream -> all outputs 0, regWrite_WB stays 0 for the next cycle; repeat REQ-034 with HAZARD_FORWARD_EN undefined -> stall held 2 cycles, codes 00.

Source files
------------

// File: rtl/ex_mem_forward_pkg.sv
// Shared definitions for the EX/MEM pipeline register and its hazard/forwarding logic.
// Forward-select encodings, ctrl_EX bit positions and register-index helpers.
package ex_mem_forward_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CTRL_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int CTRL_REGWRITE = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_BRANCH   = 0;

   // Field order matches the CTRL_* indices above (MSB first).
   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic memToReg;
      logic branch;
   } ctrl_t;

   typedef logic [REG_W-1:0] regIdx_t;

   // Register 0 is hardwired, so it can never be a real dependency.
   function automatic logic regHit(input regIdx_t dst, input regIdx_t src, input logic en);
      return en && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/ex_mem_forward_hazard_compare.sv
// Per-source-register dependency check: next forward select and stall request.
// HAZARD_FORWARD_EN selects forwarding; otherwise every dependency stalls.
module hazard_compare
   import ex_mem_forward_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic [REG_W-1:0] rdEx,
   input  logic             regWriteEx,
   input  logic             memReadEx,
   input  logic [REG_W-1:0] rdMem,
   input  logic             regWriteMem,
   output logic [1:0]       fwdNext,
   output logic             stallHit
);

   logic exHit;
   logic memHit;

   assign exHit  = regHit(rdEx, src, regWriteEx);
   assign memHit = regHit(rdMem, src, regWriteMem);

`ifdef HAZARD_FORWARD_EN
   // The younger producer (currently in EX) wins over the one in MEM.
   always_comb begin
      fwdNext = FWD_REG;
      if (exHit) begin
         fwdNext = FWD_MEM;
      end else if (memHit) begin
         fwdNext = FWD_WB;
      end
   end

   assign stallHit = regHit(rdEx, src, memReadEx);
`else
   logic unusedMemRead;

   assign unusedMemRead = memReadEx;
   assign fwdNext       = FWD_REG;
   assign stallHit      = exHit | memHit;
`endif

endmodule

// File: rtl/ex_mem_forward.sv
// EX/MEM and MEM/WB pipeline registers with branch resolution, write-back mux and
// registered forward selects. Optional macro: HAZARD_FORWARD_EN.
module ex_mem_forward
   import ex_mem_forward_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        valid_EX,
   input  logic [4:0]  RD,
   input  logic [31:0] saidaULA,
   input  logic [31:0] dado2ALU_out,
   input  logic [31:0] saidaSomador,
   input  logic        zeroEx,
   input  logic [4:0]  ctrl_EX,
   input  logic [4:0]  rs_ID,
   input  logic [4:0]  rt_ID,
   input  logic [31:0] dadoMem,
   output logic [31:0] resultadoALU_MEM,
   output logic [31:0] dado2_MEM,
   output logic        memRead_MEM,
   output logic        memWrite_MEM,
   output logic        pcSrc,
   output logic [31:0] destino,
   output logic [31:0] resultadoMux_WB,
   output logic [4:0]  RD_WB,
   output logic        regWrite_WB,
   output logic [1:0]  saidaAfw,
   output logic [1:0]  saidaBfw,
   output logic        stall
);

   ctrl_t              ctrlIn;
   ctrl_t              ctrlMem;
   logic [REG_W-1:0]   rdMem;
   logic               zeroMem;
   logic               flush;
   logic               regWriteEx;
   logic               memReadEx;

   logic               memToRegWb;
   logic [DATA_W-1:0]  aluWb;
   logic [DATA_W-1:0]  dadoMemWb;

   logic [1:0]         fwdNextA;
   logic [1:0]         fwdNextB;
   logic               stallA;
   logic               stallB;

   assign ctrlIn     = ctrl_t'(ctrl_EX);
   assign flush      = ~valid_EX | pcSrc;
   assign regWriteEx = valid_EX & ctrlIn.regWrite;
   assign memReadEx  = valid_EX & ctrlIn.memRead;

   // ---- EX -> MEM boundary
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         resultadoALU_MEM <= '0;
         dado2_MEM        <= '0;
         destino          <= '0;
         zeroMem          <= 1'b0;
         rdMem            <= '0;
         ctrlMem          <= '0;
      end else begin
         resultadoALU_MEM <= saidaULA;
         dado2_MEM        <= dado2ALU_out;
         destino          <= saidaSomador;
         zeroMem          <= zeroEx;
         rdMem            <= RD;
         ctrlMem          <= flush ? ctrl_t'('0) : ctrlIn;
      end
   end

   assign memRead_MEM  = ctrlMem.memRead;
   assign memWrite_MEM = ctrlMem.memWrite;
   assign pcSrc        = ctrlMem.branch & zeroMem;

   // ---- MEM -> WB boundary
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         RD_WB       <= '0;
         regWrite_WB <= 1'b0;
         memToRegWb  <= 1'b0;
         aluWb       <= '0;
         dadoMemWb   <= '0;
      end else begin
         RD_WB       <= rdMem;
         regWrite_WB <= ctrlMem.regWrite;
         memToRegWb  <= ctrlMem.memToReg;
         aluWb       <= resultadoALU_MEM;
         dadoMemWb   <= dadoMem;
      end
   end

   assign resultadoMux_WB = memToRegWb ? dadoMemWb : aluWb;

   hazard_compare uCmpA (
      .src         (rs_ID),
      .rdEx        (RD),
      .regWriteEx  (regWriteEx),
      .memReadEx   (memReadEx),
      .rdMem       (rdMem),
      .regWriteMem (ctrlMem.regWrite),
      .fwdNext     (fwdNextA),
      .stallHit    (stallA)
   );

   hazard_compare uCmpB (
      .src         (rt_ID),
      .rdEx        (RD),
      .regWriteEx  (regWriteEx),
      .memReadEx   (memReadEx),
      .rdMem       (rdMem),
      .regWriteMem (ctrlMem.regWrite),
      .fwdNext     (fwdNextB),
      .stallHit    (stallB)
   );

   // ---- ID -> EX boundary (forward selects for the instruction entering EX)
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         saidaAfw <= FWD_REG;
         saidaBfw <= FWD_REG;
      end else begin
         saidaAfw <= fwdNextA;
         saidaBfw <= fwdNextB;
      end
   end

   assign stall = reset_n & (stallA | stallB);

endmodule

// File: tb/tb_ex_mem_forward.sv
// Self-checking bench for ex_mem_forward using a cycle model and a scoreboard queue.
// Expectations follow HAZARD_FORWARD_EN when it is defined for the build.
module tb_ex_mem_forward;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   localparam logic [4:0] C_ALU = 5'b10000;
   localparam logic [4:0] C_LW  = 5'b11010;
   localparam logic [4:0] C_BEQ = 5'b00001;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid_EX;
   logic [4:0]  RD;
   logic [31:0] saidaULA;
   logic [31:0] dado2ALU_out;
   logic [31:0] saidaSomador;
   logic        zeroEx;
   logic [4:0]  ctrl_EX;
   logic [4:0]  rs_ID;
   logic [4:0]  rt_ID;
   logic [31:0] dadoMem;
   logic [31:0] resultadoALU_MEM;
   logic [31:0] dado2_MEM;
   logic        memRead_MEM;
   logic        memWrite_MEM;
   logic        pcSrc;
   logic [31:0] destino;
   logic [31:0] resultadoMux_WB;
   logic [4:0]  RD_WB;
   logic        regWrite_WB;
   logic [1:0]  saidaAfw;
   logic [1:0]  saidaBfw;
   logic        stall;

   int total = 0;
   int bad   = 0;

   ex_mem_forward dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .valid_EX         (valid_EX),
      .RD               (RD),
      .saidaULA         (saidaULA),
      .dado2ALU_out     (dado2ALU_out),
      .saidaSomador     (saidaSomador),
      .zeroEx           (zeroEx),
      .ctrl_EX          (ctrl_EX),
      .rs_ID            (rs_ID),
      .rt_ID            (rt_ID),
      .dadoMem          (dadoMem),
      .resultadoALU_MEM (resultadoALU_MEM),
      .dado2_MEM        (dado2_MEM),
      .memRead_MEM      (memRead_MEM),
      .memWrite_MEM     (memWrite_MEM),
      .pcSrc            (pcSrc),
      .destino          (destino),
      .resultadoMux_WB  (resultadoMux_WB),
      .RD_WB            (RD_WB),
      .regWrite_WB      (regWrite_WB),
      .saidaAfw         (saidaAfw),
      .saidaBfw         (saidaBfw),
      .stall            (stall)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] dado2;
      logic [31:0] dest;
      logic [31:0] mux;
      logic        mr;
      logic        mw;
      logic        pc;
      logic [4:0]  rdWb;
      logic        rwWb;
      logic [1:0]  afw;
      logic [1:0]  bfw;
   } exp_t;

   exp_t sb[$];

   // Reference pipeline state (ctrl bits: regWrite, memRead, memWrite, memToReg, branch).
   logic [4:0]  mCtrl = '0;
   logic [4:0]  mRd   = '0;
   logic [31:0] mAlu  = '0;
   logic [31:0] mD2   = '0;
   logic [31:0] mDest = '0;
   logic        mZero = 1'b0;
   logic [4:0]  mRdW  = '0;
   logic        mRwW  = 1'b0;
   logic        mMtrW = 1'b0;
   logic [31:0] mAluW = '0;
   logic [31:0] mDmW  = '0;
   logic [1:0]  mAfw  = '0;
   logic [1:0]  mBfw  = '0;

   function automatic logic [1:0] modelFwd(input logic [4:0] src);
      if (FWD_ON) begin
         if (valid_EX && ctrl_EX[4] && RD != 5'd0 && RD == src) return 2'b10;
         if (mCtrl[4] && mRd != 5'd0 && mRd == src) return 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic modelStall();
      logic s;
      s = 1'b0;
      if (!reset_n) return 1'b0;
      if (FWD_ON) begin
         if (valid_EX && ctrl_EX[3] && RD != 5'd0 && (RD == rs_ID || RD == rt_ID)) s = 1'b1;
      end else begin
         if (valid_EX && ctrl_EX[4] && RD != 5'd0 && (RD == rs_ID || RD == rt_ID)) s = 1'b1;
         if (mCtrl[4] && mRd != 5'd0 && (mRd == rs_ID || mRd == rt_ID)) s = 1'b1;
      end
      return s;
   endfunction

   // One clock: check stall, advance the model, push the expectation, pop after the edge.
   task automatic cycle();
      exp_t e;
      exp_t a;
      logic sExp;
      logic pcNow;
      #1;
      sExp = modelStall();
      total++;
      if (stall !== sExp) begin
         bad++;
         $display("FAIL stall: got %b want %b (t=%0t)", stall, sExp, $time);
      end
      pcNow = mCtrl[0] & mZero;
      if (!reset_n) begin
         mCtrl = '0; mRd = '0; mAlu = '0; mD2 = '0; mDest = '0; mZero = 1'b0;
         mRdW = '0; mRwW = 1'b0; mMtrW = 1'b0; mAluW = '0; mDmW = '0;
         mAfw = '0; mBfw = '0;
      end else begin
         mAfw  = modelFwd(rs_ID);
         mBfw  = modelFwd(rt_ID);
         mRdW  = mRd;
         mRwW  = mCtrl[4];
         mMtrW = mCtrl[1];
         mAluW = mAlu;
         mDmW  = dadoMem;
         mAlu  = saidaULA;
         mD2   = dado2ALU_out;
         mDest = saidaSomador;
         mZero = zeroEx;
         mRd   = RD;
         mCtrl = (!valid_EX || pcNow) ? 5'd0 : ctrl_EX;
      end
      e = '{alu: mAlu, dado2: mD2, dest: mDest, mux: (mMtrW ? mDmW : mAluW),
            mr: mCtrl[3], mw: mCtrl[2], pc: (mCtrl[0] & mZero),
            rdWb: mRdW, rwWb: mRwW, afw: mAfw, bfw: mBfw};
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      a = '{alu: resultadoALU_MEM, dado2: dado2_MEM, dest: destino, mux: resultadoMux_WB,
            mr: memRead_MEM, mw: memWrite_MEM, pc: pcSrc,
            rdWb: RD_WB, rwWb: regWrite_WB, afw: saidaAfw, bfw: saidaBfw};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL outputs: got %h want %h (t=%0t)", a, e, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] ctrl,
                        input logic [31:0] alu, input logic [4:0] rs, input logic [4:0] rt);
      valid_EX     = v;
      RD           = rd;
      ctrl_EX      = ctrl;
      saidaULA     = alu;
      dado2ALU_out = alu ^ 32'hFFFF_0000;
      saidaSomador = 32'h0;
      zeroEx       = 1'b0;
      rs_ID        = rs;
      rt_ID        = rt;
      dadoMem      = 32'h0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1'b1, 5'd6, C_LW, 32'h5555_0000, 5'd6, 5'd6);
      cycle();
      cycle();
      total++;
      if ({resultadoALU_MEM, dado2_MEM, destino, resultadoMux_WB, RD_WB, regWrite_WB,
           pcSrc, saidaAfw, saidaBfw, memRead_MEM, memWrite_MEM} !== '0) begin
         bad++;
         $display("FAIL reset_state: got alu=%h wb=%h afw=%b bfw=%b want all zero",
                  resultadoALU_MEM, resultadoMux_WB, saidaAfw, saidaBfw);
      end
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd0, 5'd0);
      cycle();
   endtask

   task automatic test_fwd_ex();
      drive(1'b1, 5'd3, C_ALU, 32'h0000_1234, 5'd3, 5'd7);
      cycle();
      total++;
      if (saidaAfw !== (FWD_ON ? 2'b10 : 2'b00) || resultadoALU_MEM !== 32'h0000_1234) begin
         bad++;
         $display("FAIL fwd_ex: got afw=%b alu=%h want afw=%b alu=00001234",
                  saidaAfw, resultadoALU_MEM, (FWD_ON ? 2'b10 : 2'b00));
      end
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd0, 5'd0);
      cycle();
      total++;
      if (resultadoMux_WB !== 32'h0000_1234 || RD_WB !== 5'd3 || regWrite_WB !== 1'b1) begin
         bad++;
         $display("FAIL wb_latency: got wb=%h rd=%0d rw=%b want 00001234 3 1",
                  resultadoMux_WB, RD_WB, regWrite_WB);
      end
   endtask

   task automatic test_priority();
      drive(1'b1, 5'd3, C_ALU, 32'h0000_0111, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd3, C_ALU, 32'h0000_0222, 5'd0, 5'd3);
      cycle();
      total++;
      if (saidaBfw !== (FWD_ON ? 2'b10 : 2'b00)) begin
         bad++;
         $display("FAIL priority: got bfw=%b want %b", saidaBfw, (FWD_ON ? 2'b10 : 2'b00));
      end
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd0, 5'd0);
      cycle();
      cycle();
   endtask

   task automatic test_load_use();
      drive(1'b1, 5'd5, C_LW, 32'h0000_0100, 5'd1, 5'd5);
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL load_use_stall: got %b want 1", stall);
      end
      cycle();
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd1, 5'd5);
      dadoMem = 32'h0000_00AA;
      #1;
      total++;
      if (stall !== !FWD_ON) begin
         bad++;
         $display("FAIL load_use_stall2: got %b want %b", stall, !FWD_ON);
      end
      cycle();
      total++;
      if (saidaBfw !== (FWD_ON ? 2'b01 : 2'b00) || resultadoMux_WB !== 32'h0000_00AA) begin
         bad++;
         $display("FAIL load_use_wb: got bfw=%b wb=%h want %b 000000aa",
                  saidaBfw, resultadoMux_WB, (FWD_ON ? 2'b01 : 2'b00));
      end
      drive(1'b1, 5'd8, C_ALU, 32'h0000_0008, 5'd1, 5'd5);
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL load_use_release: got %b want 0", stall);
      end
      cycle();
   endtask

   task automatic test_branch();
      drive(1'b1, 5'd0, C_BEQ, 32'h0, 5'd0, 5'd0);
      zeroEx       = 1'b1;
      saidaSomador = 32'h0000_0040;
      cycle();
      total++;
      if (pcSrc !== 1'b1 || destino !== 32'h0000_0040) begin
         bad++;
         $display("FAIL branch: got pcSrc=%b destino=%h want 1 00000040", pcSrc, destino);
      end
      drive(1'b1, 5'd9, C_LW | 5'b00101, 32'h0000_0099, 5'd0, 5'd0);
      zeroEx = 1'b1;
      cycle();
      total++;
      if (memRead_MEM !== 1'b0 || memWrite_MEM !== 1'b0 || pcSrc !== 1'b0) begin
         bad++;
         $display("FAIL flush: got mr=%b mw=%b pc=%b want 0 0 0", memRead_MEM, memWrite_MEM, pcSrc);
      end
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd0, 5'd0);
      cycle();
      total++;
      if (regWrite_WB !== 1'b0) begin
         bad++;
         $display("FAIL flush_wb: got regWrite_WB=%b want 0", regWrite_WB);
      end
   endtask

   task automatic test_reg0();
      drive(1'b1, 5'd0, C_ALU, 32'h0000_7777, 5'd0, 5'd0);
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL reg0_stall: got %b want 0", stall);
      end
      cycle();
      drive(1'b1, 5'd0, C_LW, 32'h0000_7778, 5'd0, 5'd0);
      cycle();
      total++;
      if (saidaAfw !== 2'b00 || saidaBfw !== 2'b00) begin
         bad++;
         $display("FAIL reg0_codes: got afw=%b bfw=%b want 00 00", saidaAfw, saidaBfw);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 5'd4, C_ALU, 32'h0000_0444, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd5, C_LW, 32'h0000_0555, 5'd4, 5'd0);
      cycle();
      reset_n = 1'b0;
      drive(1'b1, 5'd6, C_LW, 32'h0000_0666, 5'd6, 5'd5);
      cycle();
      total++;
      if ({resultadoALU_MEM, resultadoMux_WB, RD_WB, regWrite_WB, pcSrc,
           saidaAfw, saidaBfw, memRead_MEM} !== '0) begin
         bad++;
         $display("FAIL reset_mid: got alu=%h wb=%h rw=%b afw=%b bfw=%b want all zero",
                  resultadoALU_MEM, resultadoMux_WB, regWrite_WB, saidaAfw, saidaBfw);
      end
      reset_n = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 32'h0, 5'd0, 5'd0);
      cycle();
      total++;
      if (regWrite_WB !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_wb: got regWrite_WB=%b want 0", regWrite_WB);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         reset_n      = ($urandom_range(0, 39) != 0);
         valid_EX     = ($urandom_range(0, 3) != 0);
         RD           = 5'($urandom_range(0, 3));
         ctrl_EX      = 5'($urandom);
         saidaULA     = $urandom;
         dado2ALU_out = $urandom;
         saidaSomador = $urandom;
         zeroEx       = 1'($urandom);
         rs_ID        = 5'($urandom_range(0, 3));
         rt_ID        = 5'($urandom_range(0, 3));
         dadoMem      = $urandom;
         cycle();
      end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fwd_ex();
      test_priority();
      test_load_use();
      test_branch();
      test_reg0();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
